fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer driving a PC/MD register block and a memory read port.
module fetch_seq #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [17:0] bus_in,
   input  logic        mem_ack,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [12:0] redirect_pc,
   output logic        read_pc_en,
   output logic        inc_pc,
   output logic        read_md_en,
   output logic        write_mem_md,
   output logic        write_pc_en,
   output logic [17:0] pc_data,
   output logic        mem_rd,
   output logic [12:0] mem_addr,
   output logic [17:0] ir,
   output logic        ir_valid,
   output logic        busy,
   output logic        fetch_err,
   output logic [15:0] fetch_cnt
);
   typedef enum logic [3:0] {IDLE, PC_OUT, PC_LAT, MEM_RD, MD_OUT, IR_LD, HOLD, REDIR, ERR} state_t;
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   state_t state, next;
   logic [TW-1:0] tcnt;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = redirect ? REDIR : run ? PC_OUT : IDLE;
         PC_OUT:  next = PC_LAT;
         PC_LAT:  next = MEM_RD;
         MEM_RD:  next = mem_ack ? MD_OUT : (tcnt == TW'(ACK_TIMEOUT - 1)) ? ERR : MEM_RD;
         MD_OUT:  next = IR_LD;
         IR_LD:   next = HOLD;
         HOLD:    next = !ir_ready ? HOLD : redirect ? REDIR : run ? PC_OUT : IDLE;
         REDIR:   next = run ? PC_OUT : IDLE;
         ERR:     next = ERR;
         default: next = IDLE;
      endcase
   end
   always_comb begin
      read_pc_en   = state == PC_OUT;
      read_md_en   = state == MD_OUT;
      inc_pc       = state == MD_OUT;
      write_pc_en  = state == REDIR;
      write_mem_md = state == MEM_RD && mem_ack && !rst;
   end
   // redirect target is captured only on acceptance, i.e. when IDLE/HOLD moves to REDIR
   always_ff @(posedge clk)
      if (rst) begin
         tcnt      <= '0;
         mem_rd    <= 1'b0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         pc_data   <= '0;
         fetch_err <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         tcnt     <= (state == MEM_RD) ? tcnt + TW'(1) : '0;
         mem_rd   <= next == MEM_RD;
         busy     <= next != IDLE && next != ERR;
         ir_valid <= next == HOLD;
         if (state == PC_LAT) mem_addr <= bus_in[12:0];
         if (state == IR_LD) begin
            ir        <= bus_in;
            fetch_cnt <= fetch_cnt + 16'd1;
         end
         if (next == REDIR && state != REDIR) pc_data <= {5'b0, redirect_pc};
         if (next == ERR) fetch_err <= 1'b1;
      end
endmodule
